// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state encoding, speed codes and defaults for the count sequencer
package counter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_LOAD  = 3'd3,
    ST_CLEAR = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Rate select codes on the speed switches
  localparam logic [1:0] SPD_EVERY   = 2'b00;
  localparam logic [1:0] SPD_1HZ     = 2'b01;
  localparam logic [1:0] SPD_HALF_HZ = 2'b10;
  localparam logic [1:0] SPD_QTR_HZ  = 2'b11;

  // 50 MHz board clock; divider must hold 4*TPS-1
  localparam int DEFAULT_TPS   = 50000000;
  localparam int DEFAULT_DIV_W = 28;

  localparam logic [3:0] COUNT_MAX = 4'hF;

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - reloadable down-counter producing the count-enable tick while running
module tick_divider
  import counter_pkg::*;
#(
  parameter int TICKS_PER_SEC = DEFAULT_TPS,
  parameter int DIV_W         = DEFAULT_DIV_W
) (
  input  logic       i_clk,
  input  logic       i_clear_b,
  input  logic [1:0] i_speed,
  input  logic       i_run,
  output logic       o_tick
);

  localparam logic [DIV_W-1:0] RELOAD_1HZ  = DIV_W'(TICKS_PER_SEC - 1);
  localparam logic [DIV_W-1:0] RELOAD_HALF = DIV_W'(2 * TICKS_PER_SEC - 1);
  localparam logic [DIV_W-1:0] RELOAD_QTR  = DIV_W'(4 * TICKS_PER_SEC - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [1:0]       r_speed_q;
  logic [DIV_W-1:0] w_reload;
  logic             w_speed_chg;

  // Reload value for the currently selected rate (period is reload+1 cycles)
  always_comb begin
    w_reload = '0;
    case (i_speed)
      SPD_EVERY:   w_reload = '0;
      SPD_1HZ:     w_reload = RELOAD_1HZ;
      SPD_HALF_HZ: w_reload = RELOAD_HALF;
      SPD_QTR_HZ:  w_reload = RELOAD_QTR;
      default:     w_reload = '0;
    endcase
  end

  // A switch change restarts the period and suppresses that cycle's tick
  assign w_speed_chg = (i_speed != r_speed_q);
  assign o_tick      = i_run && !w_speed_chg && (r_div_cnt == '0);

  // Count down only while running; otherwise park at the reload value
  always_ff @(posedge i_clk) begin
    if (!i_clear_b) begin
      r_div_cnt <= w_reload;
      r_speed_q <= i_speed;
    end else if (w_speed_chg) begin
      r_div_cnt <= w_reload;
      r_speed_q <= i_speed;
    end else if (i_run) begin
      if (r_div_cnt == '0) begin
        r_div_cnt <= w_reload;
      end else begin
        r_div_cnt <= r_div_cnt - 1'b1;
      end
    end else begin
      r_div_cnt <= w_reload;
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// rtl/count_sequencer.sv - run/pause/load/clear/one-shot controller for the hex display counter
module count_sequencer
  import counter_pkg::*;
#(
  parameter int TICKS_PER_SEC = DEFAULT_TPS,
  parameter int DIV_W         = DEFAULT_DIV_W
) (
  input  logic       clock,
  input  logic       Clear_b,
  input  logic [1:0] speed,
  input  logic       start,
  input  logic       stop,
  input  logic       load_req,
  input  logic [3:0] load_val,
  input  logic       clear_req,
  input  logic       one_shot,
  input  logic [3:0] count_q,
  output logic       cnt_enable,
  output logic       cnt_parload,
  output logic       cnt_clear_b,
  output logic [3:0] cnt_d,
  output logic [2:0] state_o,
  output logic       done
);

  state_t     r_state;
  logic       r_cnt_enable;
  logic       r_cnt_parload;
  logic       r_cnt_clear_b;
  logic [3:0] r_cnt_d;
  logic       r_done;
  logic       w_run;
  logic       w_tick;

  assign w_run = (r_state == ST_RUN);

  tick_divider #(
    .TICKS_PER_SEC(TICKS_PER_SEC),
    .DIV_W        (DIV_W)
  ) u_tick_divider (
    .i_clk    (clock),
    .i_clear_b(Clear_b),
    .i_speed  (speed),
    .i_run    (w_run),
    .o_tick   (w_tick)
  );

  // Sequencer FSM; every counter control is a registered one-cycle decision
  always_ff @(posedge clock) begin
    if (!Clear_b) begin
      r_state       <= ST_IDLE;
      r_cnt_enable  <= 1'b0;
      r_cnt_parload <= 1'b0;
      r_cnt_clear_b <= 1'b0;
      r_cnt_d       <= 4'h0;
      r_done        <= 1'b0;
    end else begin
      r_cnt_enable  <= 1'b0;
      r_cnt_parload <= 1'b0;
      r_cnt_clear_b <= 1'b1;
      r_done        <= 1'b0;
      case (r_state)
        // Load/clear pulses last one cycle; a held request re-fires after IDLE
        ST_LOAD, ST_CLEAR: r_state <= ST_IDLE;
        default: begin
          if (clear_req) begin
            r_state       <= ST_CLEAR;
            r_cnt_clear_b <= 1'b0;
          end else if (load_req) begin
            r_state       <= ST_LOAD;
            r_cnt_parload <= 1'b1;
            r_cnt_d       <= load_val;
          end else begin
            case (r_state)
              ST_RUN: begin
                if (stop) begin
                  r_state <= ST_PAUSE;
                end else if (w_tick) begin
                  if (one_shot && (count_q == COUNT_MAX)) begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                  end else begin
                    r_cnt_enable <= 1'b1;
                  end
                end
              end
              ST_DONE: r_done <= 1'b1;
              ST_IDLE, ST_PAUSE: begin
                if (!stop && start) begin
                  r_state <= ST_RUN;
                end
              end
              default: r_state <= ST_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign cnt_enable  = r_cnt_enable;
  assign cnt_parload = r_cnt_parload;
  assign cnt_clear_b = r_cnt_clear_b;
  assign cnt_d       = r_cnt_d;
  assign state_o     = r_state;
  assign done        = r_done;

endmodule

// File: tb/tb_count_sequencer.sv
// tb/tb_count_sequencer.sv - randomized and directed bench for count_sequencer with an attached counter
module tb_count_sequencer;

  localparam int TPS = 4;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_LOAD  = 3;
  localparam int M_CLEAR = 4;
  localparam int M_DONE  = 5;

  logic       clock = 1'b0;
  logic       Clear_b;
  logic [1:0] speed;
  logic       start, stop, load_req, clear_req, one_shot;
  logic [3:0] load_val;
  logic [3:0] count_q;
  logic       cnt_enable, cnt_parload, cnt_clear_b, done;
  logic [3:0] cnt_d;
  logic [2:0] state_o;

  int total = 0;
  int bad   = 0;

  // reference model state
  int         m_state;
  bit         m_en, m_pl, m_cb, m_done;
  logic [3:0] m_d;
  logic [1:0] m_spd;
  int         m_el;
  logic [3:0] m_cnt;

  always #5 clock = ~clock;

  count_sequencer #(
    .TICKS_PER_SEC(TPS),
    .DIV_W        (8)
  ) dut (
    .clock      (clock),
    .Clear_b    (Clear_b),
    .speed      (speed),
    .start      (start),
    .stop       (stop),
    .load_req   (load_req),
    .load_val   (load_val),
    .clear_req  (clear_req),
    .one_shot   (one_shot),
    .count_q    (count_q),
    .cnt_enable (cnt_enable),
    .cnt_parload(cnt_parload),
    .cnt_clear_b(cnt_clear_b),
    .cnt_d      (cnt_d),
    .state_o    (state_o),
    .done       (done)
  );

  // attached 4-bit display counter on the same clock
  always_ff @(posedge clock) begin
    if (!Clear_b || !cnt_clear_b) count_q <= 4'h0;
    else if (cnt_parload)        count_q <= cnt_d;
    else if (cnt_enable)         count_q <= count_q + 4'h1;
  end

  function automatic int period_of(input logic [1:0] s);
    case (s)
      2'd0:    return 1;
      2'd1:    return TPS;
      2'd2:    return 2 * TPS;
      default: return 4 * TPS;
    endcase
  endfunction

  // One clock edge of the reference: m_el counts cycles spent in RUN since the period began
  task automatic model_edge();
    bit         o_en = m_en;
    bit         o_pl = m_pl;
    bit         o_cb = m_cb;
    logic [3:0] o_d  = m_d;
    bit         tk;
    tk = (m_state == M_RUN) && (speed == m_spd) && (m_el + 1 == period_of(m_spd));
    if (!Clear_b) begin
      m_state = M_IDLE; m_en = 0; m_pl = 0; m_cb = 0; m_d = 4'h0; m_done = 0;
      m_spd = speed; m_el = 0;
    end else begin
      if (speed != m_spd) begin m_spd = speed; m_el = 0; end
      else if (m_state == M_RUN) m_el = tk ? 0 : m_el + 1;
      else m_el = 0;
      m_en = 0; m_pl = 0; m_cb = 1;
      if (m_state == M_CLEAR || m_state == M_LOAD) m_state = M_IDLE;
      else if (clear_req) begin m_state = M_CLEAR; m_cb = 0; end
      else if (load_req) begin m_state = M_LOAD; m_pl = 1; m_d = load_val; end
      else if (m_state == M_DONE) begin m_state = M_DONE; end
      else if (m_state == M_RUN) begin
        if (stop) m_state = M_PAUSE;
        else if (tk) begin
          if (one_shot && m_cnt == 4'hF) m_state = M_DONE;
          else m_en = 1;
        end
      end
      else if (!stop && start) m_state = M_RUN;
      m_done = (m_state == M_DONE);
    end
    if (!Clear_b || !o_cb) m_cnt = 4'h0;
    else if (o_pl)         m_cnt = o_d;
    else if (o_en)         m_cnt = m_cnt + 4'h1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      model_edge();
      #1;
      chk("state",   8'(state_o),     8'(m_state));
      chk("enable",  8'(cnt_enable),  8'(m_en));
      chk("parload", 8'(cnt_parload), 8'(m_pl));
      chk("clear_b", 8'(cnt_clear_b), 8'(m_cb));
      chk("d",       8'(cnt_d),       8'(m_d));
      chk("done",    8'(done),        8'(m_done));
      chk("count",   8'(count_q),     8'(m_cnt));
    end
  endtask

  initial begin
    Clear_b = 0; speed = 2'd1; start = 0; stop = 0; load_req = 0; load_val = 4'h0;
    clear_req = 0; one_shot = 0;
    m_state = M_IDLE; m_en = 0; m_pl = 0; m_cb = 0; m_done = 0; m_d = 4'h0;
    m_spd = 2'd1; m_el = 0; m_cnt = 4'h0;
    step(2);
    Clear_b = 1;
    step(2);

    // 1 Hz run long enough for 0..F and wrap
    start = 1;
    step(70);
    start = 0;

    // slowest rate, then switch to every-cycle mid-period
    speed = 2'd3; step(7);
    speed = 2'd0; step(10);

    // pause for 10 cycles and resume at 1 Hz
    speed = 2'd1; step(5);
    stop = 1; start = 1; step(10);
    stop = 0; step(12);

    // parallel load of A while running, then another random value
    load_req = 1; load_val = 4'hA; step(1);
    load_req = 0; start = 0; step(3);
    load_req = 1; load_val = 4'($urandom_range(0, 15)); step(1);
    load_req = 0; step(2);

    // one-shot at full rate stops at F and ignores start/stop
    one_shot = 1; speed = 2'd0; start = 1; step(25);
    stop = 1; step(2); stop = 0; step(3);
    clear_req = 1; step(1);
    clear_req = 0; start = 0; step(3);
    one_shot = 0;

    // held clear re-triggers through IDLE
    clear_req = 1; step(5);
    clear_req = 0; step(1);

    // reset mid-run with every request asserted, then requests alone
    start = 1; step(6);
    Clear_b = 0; clear_req = 1; load_req = 1; step(1);
    Clear_b = 1; step(1);
    clear_req = 0; load_req = 0; step(4);

    // random traffic
    for (int k = 0; k < 1500; k++) begin
      Clear_b   = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 39) == 0) speed = 2'($urandom_range(0, 3));
      start     = ($urandom_range(0, 3) == 0);
      stop      = ($urandom_range(0, 19) == 0);
      load_req  = ($urandom_range(0, 49) == 0);
      clear_req = ($urandom_range(0, 79) == 0);
      load_val  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) one_shot = ~one_shot;
      step(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
